// File: rtl/extrap_channel_scheduler.sv
// extrap_channel_scheduler
// Time-multiplexes one gap-fill/extrapolation datapath across NCH sample channels.
// Samples are captured per channel at any time. On an idle frame_tick the captured
// set is frozen into a shadow copy, and channels are issued one at a time, index 0
// first. Each result is collected and re-emitted on out_*. A per-channel miss
// counter drives ch_stale.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   frame_tick        start-of-frame pulse
//   ch_valid/sample   per-channel sample strobe and data (lane k at [k*DW +: DW])
//   dp_*              request to / result from the shared datapath
//   out_*             collected gap-filled result, one pulse per channel
//   busy              frame scan in progress
//   ch_stale          channel has missed MAX_MISS or more consecutive frames
//   overrun           sticky: frame_tick seen while busy
module extrap_channel_scheduler #(
    parameter int NCH      = 4,
    parameter int DW       = 16,
    parameter int DP_LAT   = 1,
    parameter int MAX_MISS = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_tick,
    input  logic [NCH-1:0]    ch_valid,
    input  logic [NCH*DW-1:0] ch_sample,
    output logic              dp_strobe,
    output logic [2:0]        dp_ch,
    output logic              dp_valid_in,
    output logic [DW-1:0]     dp_sample_in,
    input  logic [DW-1:0]     dp_sample_out,
    output logic              out_valid,
    output logic [2:0]        out_ch,
    output logic [DW-1:0]     out_sample,
    output logic              busy,
    output logic [NCH-1:0]    ch_stale,
    output logic              overrun
);
    localparam int            IW        = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] IDX_LAST  = IW'(NCH - 1);
    // Last value of the WAIT counter; unused when DP_LAT=1 because WAIT is skipped.
    localparam logic [1:0]    WAIT_LAST = 2'((DP_LAT > 1) ? DP_LAT - 2 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COLLECT} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [1:0]      wait_q, wait_d;
    logic [DW-1:0]   cap_q [NCH];
    logic [DW-1:0]   cap_d [NCH];
    logic [DW-1:0]   shadow_q [NCH];
    logic [DW-1:0]   shadow_d [NCH];
    logic [2:0]      miss_q [NCH];
    logic [2:0]      miss_d [NCH];
    logic [NCH-1:0]  pend_q, pend_d;
    logic [NCH-1:0]  spend_q, spend_d;
    logic [NCH-1:0]  stale_q, stale_d;
    logic            overrun_q, overrun_d;
    logic            out_valid_q, out_valid_d;
    logic [2:0]      out_ch_q, out_ch_d;
    logic [DW-1:0]   out_sample_q, out_sample_d;
    logic            accept;

    // A tick is only honoured from IDLE; anything else is an overrun.
    assign accept = frame_tick && (state_q == IDLE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                end
            end
            ISSUE: begin
                wait_d  = '0;
                state_d = (DP_LAT > 1) ? WAIT : COLLECT;
            end
            WAIT: begin
                if (wait_q == WAIT_LAST) state_d = COLLECT;
                else                     wait_d  = wait_q + 2'd1;
            end
            COLLECT: begin
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        dp_strobe    = 1'b0;
        dp_ch        = '0;
        dp_valid_in  = 1'b0;
        dp_sample_in = '0;
        if (state_q == ISSUE) begin
            dp_strobe    = 1'b1;
            dp_ch        = 3'(idx_q);
            dp_valid_in  = spend_q[idx_q];
            dp_sample_in = spend_q[idx_q] ? shadow_q[idx_q] : '0;
        end
    end

    assign busy = (state_q != IDLE);

    // ---------------- capture, snapshot, miss tracking, results ----------------
    always_comb begin
        // On accept the pending set moves to the shadow side; a strobe landing in
        // the same cycle re-arms pend below and belongs to the next frame.
        pend_d    = accept ? '0 : pend_q;
        spend_d   = accept ? pend_q : spend_q;
        overrun_d = overrun_q | (frame_tick && (state_q != IDLE));
        for (int k = 0; k < NCH; k++) begin
            cap_d[k]    = cap_q[k];
            shadow_d[k] = accept ? cap_q[k] : shadow_q[k];
            if (ch_valid[k]) begin
                cap_d[k]  = ch_sample[k*DW +: DW];
                pend_d[k] = 1'b1;
            end
            miss_d[k] = miss_q[k];
            if ((state_q == ISSUE) && (idx_q == IW'(k))) begin
                if (spend_q[k])              miss_d[k] = 3'd0;
                else if (miss_q[k] != 3'd7)  miss_d[k] = miss_q[k] + 3'd1;
            end
            stale_d[k] = (miss_q[k] >= 3'(MAX_MISS));
        end
        out_valid_d  = (state_q == COLLECT);
        out_ch_d     = (state_q == COLLECT) ? 3'(idx_q) : out_ch_q;
        out_sample_d = (state_q == COLLECT) ? dp_sample_out : out_sample_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NCH; k++) begin
                cap_q[k]    <= '0;
                shadow_q[k] <= '0;
                miss_q[k]   <= '0;
            end
            pend_q       <= '0;
            spend_q      <= '0;
            stale_q      <= '0;
            overrun_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_sample_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                cap_q[k]    <= cap_d[k];
                shadow_q[k] <= shadow_d[k];
                miss_q[k]   <= miss_d[k];
            end
            pend_q       <= pend_d;
            spend_q      <= spend_d;
            stale_q      <= stale_d;
            overrun_q    <= overrun_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_sample_q <= out_sample_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign out_sample = out_sample_q;
    assign ch_stale   = stale_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_extrap_channel_scheduler.sv
module tb_extrap_channel_scheduler;
    localparam logic [15:0] FILL = 16'h0BAD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic [3:0]  ch_valid = '0;
    logic [63:0] ch_sample = '0;
    logic        dp_strobe, dp_valid_in, out_valid, busy, overrun;
    logic [2:0]  dp_ch, out_ch;
    logic [15:0] dp_sample_in, out_sample;
    logic [15:0] dp_sample_out = '0;
    logic [3:0]  ch_stale;

    int checks = 0;
    int errors = 0;

    // observations recorded over one scan
    int          ns, no, nbusy;
    int          s_cyc [8];
    logic [2:0]  s_ch  [8];
    logic        s_v   [8];
    logic [15:0] s_smp [8];
    int          o_cyc [8];
    logic [2:0]  o_ch  [8];
    logic [15:0] o_smp [8];

    // expected per-channel issue/result for the current test
    logic        e_v   [4];
    logic [15:0] e_in  [4];
    logic [15:0] e_out [4];

    extrap_channel_scheduler dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .ch_valid(ch_valid), .ch_sample(ch_sample),
        .dp_strobe(dp_strobe), .dp_ch(dp_ch), .dp_valid_in(dp_valid_in),
        .dp_sample_in(dp_sample_in), .dp_sample_out(dp_sample_out),
        .out_valid(out_valid), .out_ch(out_ch), .out_sample(out_sample),
        .busy(busy), .ch_stale(ch_stale), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // datapath model, latency 1: echo fresh samples, substitute FILL for misses
    always @(posedge clk)
        if (dp_strobe) dp_sample_out <= dp_valid_in ? dp_sample_in : FILL;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] m, input logic [15:0] v0, v1, v2, v3);
        ch_valid  = m;
        ch_sample = {v3, v2, v1, v0};
        step();
        ch_valid = '0;
    endtask

    // Raises frame_tick for one cycle, then records every issue/result over a
    // bounded window. Cycle 1 is the first cycle after the tick edge.
    task automatic do_scan();
        ns = 0; no = 0; nbusy = 0;
        for (int i = 0; i < 8; i++) begin
            s_cyc[i] = -1; s_ch[i] = 'x; s_v[i] = 1'bx; s_smp[i] = 'x;
            o_cyc[i] = -1; o_ch[i] = 'x; o_smp[i] = 'x;
        end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        ch_valid   = '0;
        for (int c = 1; c <= 11; c++) begin
            if (dp_strobe) begin
                if (ns < 8) begin
                    s_cyc[ns] = c; s_ch[ns] = dp_ch; s_v[ns] = dp_valid_in; s_smp[ns] = dp_sample_in;
                end
                ns++;
            end
            if (out_valid) begin
                if (no < 8) begin
                    o_cyc[no] = c; o_ch[no] = out_ch; o_smp[no] = out_sample;
                end
                no++;
            end
            if (busy) nbusy++;
            step();
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        ch_valid = 4'hF; frame_tick = 1'b1;
        #2;
        checks++;
        if ({dp_strobe, dp_ch, dp_valid_in, dp_sample_in, out_valid, out_ch, out_sample,
             busy, ch_stale, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got strobe=%b busy=%b outv=%b stale=%b ovr=%b exp all 0",
                     dp_strobe, busy, out_valid, ch_stale, overrun);
        end
        step(); step();
        checks++;
        if ({dp_strobe, out_valid, busy, ch_stale, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_held got strobe=%b outv=%b busy=%b stale=%b ovr=%b exp all 0",
                     dp_strobe, out_valid, busy, ch_stale, overrun);
        end
        ch_valid = '0; frame_tick = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_all_present();
        strobe(4'hF, 16'd100, 16'd200, 16'hFED4, 16'd400);
        e_in = '{16'd100, 16'd200, 16'hFED4, 16'd400};
        do_scan();
        checks++;
        if (ns !== 4 || no !== 4 || nbusy !== 8) begin
            errors++;
            $display("FAIL ap_counts got strobes=%0d outs=%0d busy=%0d exp 4 4 8", ns, no, nbusy);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (s_cyc[i] !== 2*i+1 || s_ch[i] !== 3'(i) || s_v[i] !== 1'b1 || s_smp[i] !== e_in[i]) begin
                errors++;
                $display("FAIL ap_issue%0d got cyc=%0d ch=%0d v=%b smp=%h exp cyc=%0d ch=%0d v=1 smp=%h",
                         i, s_cyc[i], s_ch[i], s_v[i], s_smp[i], 2*i+1, i, e_in[i]);
            end
            checks++;
            if (o_cyc[i] !== 2*i+3 || o_ch[i] !== 3'(i) || o_smp[i] !== e_in[i]) begin
                errors++;
                $display("FAIL ap_out%0d got cyc=%0d ch=%0d smp=%h exp cyc=%0d ch=%0d smp=%h",
                         i, o_cyc[i], o_ch[i], o_smp[i], 2*i+3, i, e_in[i]);
            end
        end
    endtask

    task automatic test_missing_ch2();
        e_v   = '{1'b1, 1'b1, 1'b0, 1'b1};
        e_in  = '{16'd1, 16'd2, 16'd0, 16'd4};
        e_out = '{16'd1, 16'd2, FILL, 16'd4};
        for (int f = 1; f <= 4; f++) begin
            strobe(4'b1011, 16'd1, 16'd2, 16'd3, 16'd4);
            do_scan();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (s_v[i] !== e_v[i] || s_smp[i] !== e_in[i] || o_smp[i] !== e_out[i]) begin
                    errors++;
                    $display("FAIL miss_f%0d_ch%0d got v=%b in=%h out=%h exp v=%b in=%h out=%h",
                             f, i, s_v[i], s_smp[i], o_smp[i], e_v[i], e_in[i], e_out[i]);
                end
            end
            checks++;
            if (ch_stale !== ((f >= 3) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL miss_stale_f%0d got %b exp %b", f, ch_stale, (f >= 3) ? 4'b0100 : 4'b0000);
            end
        end
        strobe(4'hF, 16'd1, 16'd2, 16'd3, 16'd4);
        do_scan();
        checks++;
        if (s_v[2] !== 1'b1 || s_smp[2] !== 16'd3 || ch_stale !== 4'b0000) begin
            errors++;
            $display("FAIL miss_recover got v=%b smp=%h stale=%b exp v=1 smp=0003 stale=0000",
                     s_v[2], s_smp[2], ch_stale);
        end
    endtask

    task automatic test_overrun();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_initial got %b exp 0", overrun);
        end
        strobe(4'hF, 16'd1, 16'd2, 16'd3, 16'd4);
        fork
            do_scan();
            begin
                repeat (2) @(posedge clk);
                #2 ch_valid = 4'b0010; ch_sample[31:16] = 16'd9;
                @(posedge clk);
                #2 ch_valid = '0; frame_tick = 1'b1;
                @(posedge clk);
                #2 frame_tick = 1'b0;
            end
        join
        checks++;
        if (overrun !== 1'b1 || ns !== 4 || no !== 4 || nbusy !== 8) begin
            errors++;
            $display("FAIL ovr_scan got ovr=%b strobes=%0d outs=%0d busy=%0d exp 1 4 4 8", overrun, ns, no, nbusy);
        end
        e_in = '{16'd1, 16'd2, 16'd3, 16'd4};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (s_v[i] !== 1'b1 || s_smp[i] !== e_in[i] || o_smp[i] !== e_in[i] || o_ch[i] !== 3'(i)) begin
                errors++;
                $display("FAIL ovr_ch%0d got v=%b in=%h out=%h och=%0d exp v=1 in=%h out=%h och=%0d",
                         i, s_v[i], s_smp[i], o_smp[i], o_ch[i], e_in[i], e_in[i], i);
            end
        end
        do_scan();
        e_v   = '{1'b0, 1'b1, 1'b0, 1'b0};
        e_in  = '{16'd0, 16'd9, 16'd0, 16'd0};
        e_out = '{FILL, 16'd9, FILL, FILL};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (s_v[i] !== e_v[i] || s_smp[i] !== e_in[i] || o_smp[i] !== e_out[i]) begin
                errors++;
                $display("FAIL ovr_next_ch%0d got v=%b in=%h out=%h exp v=%b in=%h out=%h",
                         i, s_v[i], s_smp[i], o_smp[i], e_v[i], e_in[i], e_out[i]);
            end
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky got %b exp 1", overrun);
        end
    endtask

    task automatic test_same_cycle();
        strobe(4'b1110, 16'd0, 16'd11, 16'd22, 16'd33);
        ch_valid  = 4'b0001;
        ch_sample[15:0] = 16'd55;
        do_scan();
        e_v  = '{1'b0, 1'b1, 1'b1, 1'b1};
        e_in = '{16'd0, 16'd11, 16'd22, 16'd33};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (s_v[i] !== e_v[i] || s_smp[i] !== e_in[i]) begin
                errors++;
                $display("FAIL same_f1_ch%0d got v=%b in=%h exp v=%b in=%h", i, s_v[i], s_smp[i], e_v[i], e_in[i]);
            end
        end
        do_scan();
        checks++;
        if (s_v[0] !== 1'b1 || s_smp[0] !== 16'd55 || o_smp[0] !== 16'd55 || s_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL same_f2 got v0=%b in0=%h out0=%h v1=%b exp 1 0037 0037 0",
                     s_v[0], s_smp[0], o_smp[0], s_v[1]);
        end
    endtask

    task automatic test_reset_mid_scan();
        int stray;
        strobe(4'hF, 16'd5, 16'd6, 16'd7, 16'd8);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step(); step();   // now at ISSUE of ch1, ch0 result on out_valid
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({dp_strobe, dp_ch, dp_valid_in, dp_sample_in, out_valid, out_ch, out_sample,
             busy, ch_stale, overrun} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs got strobe=%b outv=%b busy=%b ovr=%b smp=%h exp all 0",
                     dp_strobe, out_valid, busy, overrun, dp_sample_in);
        end
        stray = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (out_valid || busy) stray++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (out_valid || busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL rst_mid_stray got %0d active cycles exp 0", stray);
        end
        strobe(4'hF, 16'd10, 16'd20, 16'd30, 16'd40);
        do_scan();
        e_in = '{16'd10, 16'd20, 16'd30, 16'd40};
        checks++;
        if (ns !== 4 || no !== 4 || nbusy !== 8) begin
            errors++;
            $display("FAIL rst_mid_counts got strobes=%0d outs=%0d busy=%0d exp 4 4 8", ns, no, nbusy);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (s_v[i] !== 1'b1 || o_ch[i] !== 3'(i) || o_smp[i] !== e_in[i]) begin
                errors++;
                $display("FAIL rst_mid_ch%0d got v=%b och=%0d out=%h exp v=1 och=%0d out=%h",
                         i, s_v[i], o_ch[i], o_smp[i], i, e_in[i]);
            end
        end
    endtask

    task automatic test_last_wins_sat();
        strobe(4'hF, 16'd1, 16'd7, 16'd3, 16'd4);
        strobe(4'b0010, 16'd0, 16'hFFF8, 16'd0, 16'd0);
        do_scan();
        checks++;
        if (s_v[1] !== 1'b1 || s_smp[1] !== 16'hFFF8 || o_smp[1] !== 16'hFFF8 || s_smp[2] !== 16'd3) begin
            errors++;
            $display("FAIL last_wins got v=%b in=%h out=%h in2=%h exp 1 fff8 fff8 0003",
                     s_v[1], s_smp[1], o_smp[1], s_smp[2]);
        end
        for (int f = 1; f <= 10; f++) begin
            do_scan();
            checks++;
            if (ch_stale !== ((f >= 3) ? 4'b1111 : 4'b0000)) begin
                errors++;
                $display("FAIL sat_f%0d got stale=%b exp %b", f, ch_stale, (f >= 3) ? 4'b1111 : 4'b0000);
            end
        end
        strobe(4'b0010, 16'd0, 16'd5, 16'd0, 16'd0);
        do_scan();
        checks++;
        if (ch_stale !== 4'b1101 || s_v[1] !== 1'b1 || s_smp[1] !== 16'd5 || s_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear got stale=%b v1=%b in1=%h v0=%b exp 1101 1 0005 0",
                     ch_stale, s_v[1], s_smp[1], s_v[0]);
        end
    endtask

    initial begin
        test_reset();
        test_all_present();
        test_missing_ch2();
        test_overrun();
        test_same_cycle();
        test_reset_mid_scan();
        test_last_wins_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
